// File: rtl/dp_ram.sv
// ============================================================================
// Module   : dp_ram
// Purpose  : Simple dual-port synchronous RAM (one write, one read port) with
//            per-word valid bits so unwritten or reset words read as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  input  logic              rst_n
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]  mem [c_DEPTH];
  logic [c_DEPTH-1:0] valid_q;
  logic [c_DEPTH-1:0] valid_d;
  logic [DATA_W-1:0]  q_q;
  logic [DATA_W-1:0]  q_d;

  always_comb begin
    valid_d = valid_q;
    if (we) begin
      valid_d[wr_add] = 1'b1;
    end
  end

  // Valid is checked before the bypass: a word never written reads zero even
  // when it is being written in the same cycle.
  always_comb begin
    q_d = '0;
    if (!valid_q[rd_add]) begin
      q_d = '0;
    end else if (we && (wr_add == rd_add)) begin
      q_d = d;
    end else begin
      q_d = mem[rd_add];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_d;
      q_q     <= q_d;
    end
  end

  // Storage itself is never cleared; stale contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[wr_add] <= d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_dp_ram.sv
// ============================================================================
// Module   : tb_dp_ram
// Purpose  : Directed self-checking bench for dp_ram with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dp_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] wr_add;
  logic [ADDR_W-1:0] rd_add;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_val [DEPTH];
  logic [DATA_W-1:0] sb_q  [$];

  dp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dut (
    .clk   (clk),
    .we    (we),
    .wr_add(wr_add),
    .rd_add(rd_add),
    .d     (d),
    .q     (q),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive, predict, clock, then compare.
  task automatic step(input string tag, input logic w, input int wa, input int ra,
                      input int dv);
    logic [DATA_W-1:0] exp;
    we     = w;
    wr_add = ADDR_W'(wa);
    rd_add = ADDR_W'(ra);
    d      = DATA_W'(dv);
    if (!m_val[rd_add])                 exp = '0;
    else if (w && (wr_add == rd_add))   exp = d;
    else                                exp = m_mem[rd_add];
    sb_q.push_back(exp);
    if (w) begin
      m_mem[wr_add] = d;
      m_val[wr_add] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, q, 8'hxx);
    end else begin
      chk(tag, q, sb_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b1;
    we     = 1'b0;
    wr_add = '0;
    rd_add = '0;
    d      = '0;
    model_reset();

    // Reset then read
    #3 rst_n = 1'b0;
    #1 chk("reset_q", q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step("rd0_after_reset", 1'b0, 0, 0, 0);
    step("rd2_after_reset", 1'b0, 0, 2, 0);

    // Write then read a different address, then the written one
    step("wr2_rd3", 1'b1, 2, 3, 'hD3);
    step("wr2_rd2", 1'b1, 2, 2, 'hD3);
    chk("wr2_rd2_const", q, 8'hD3);

    // Read-during-write bypass on a valid word
    step("wr5_init", 1'b1, 5, 0, 'h11);
    step("bypass5", 1'b1, 5, 5, 'h5A);
    chk("bypass5_const", q, 8'h5A);

    // Full-range fill, reading from the opposite end
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, i, DEPTH - 1 - i, i & 'hFF);
    end
    step("wrap_1023", 1'b0, 0, 1023, 0);
    chk("wrap_1023_const", q, 8'hFF);
    step("wrap_0", 1'b0, 0, 0, 0);
    step("wrap_512", 1'b0, 0, 512, 0);

    // Mid-run asynchronous reset
    step("wr7_a5", 1'b1, 7, 7, 'hA5);
    #2 rst_n = 1'b0;
    model_reset();
    we = 1'b0;
    #1 chk("midrun_reset_q", q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step("rd7_after_reset", 1'b0, 0, 7, 0);
    step("rd1023_after_reset", 1'b0, 0, 1023, 0);
    step("wr7_3c", 1'b1, 7, 9, 'h3C);
    step("rd7_3c", 1'b0, 0, 7, 0);
    chk("rd7_3c_const", q, 8'h3C);

    // Back-to-back write with read of previous address
    step("b2b_seed", 1'b1, 99, 0, 'h0F);
    for (int k = 0; k < 16; k++) begin
      step("b2b", 1'b1, 100 + k, 99 + k, 'h10 + k);
    end
    step("b2b_last", 1'b0, 0, 115, 0);
    chk("b2b_last_const", q, 8'h1F);

    chk("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
